// File: rtl/rv32i_lsu_pkg.sv
// Shared types and helpers for the rv32i load/store unit: FSM states, store formats,
// load funct3 codes and the alignment/legality checks used at request acceptance.
package rv32i_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10,
    RESP   = 2'b11
  } lsu_state_e;

  // Encoding matches memwritefrmt; 2'b11 is the illegal format and has no member.
  typedef enum logic [1:0] {
    fmt_sb = 2'b00,
    fmt_sh = 2'b01,
    fmt_sw = 2'b10
  } store_frmt;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  // Fields of an accepted access that the unit still needs after acceptance.
  typedef struct packed {
    logic       we;
    logic [2:0] ld_op;
    logic [1:0] addr_lo;
  } lsu_req_t;

  // Access size uses the store_frmt encoding; ld_op[1:0] maps onto it for loads.
  function automatic logic lsu_misaligned(input logic [1:0] addr_lo, input logic [1:0] op);
    logic mis;
    case (op)
      fmt_sh:  mis = addr_lo[0];
      fmt_sw:  mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic lsu_ld_illegal(input logic [2:0] ld_op);
    return (ld_op == 3'b011) || (ld_op == 3'b110) || (ld_op == 3'b111);
  endfunction

endpackage

// File: rtl/rv32i_lsu_if.sv
// Request/response and data-memory port bundle of the load/store unit.
// slave is the LSU's view; master is the execute stage plus data memory.
interface rv32i_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_ld_op;
  logic [1:0]  req_st_fmt;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_ld_op, req_st_fmt, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, req_we, req_ld_op, req_st_fmt, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/rv32i_lsu_load_extract.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it
// according to the load funct3.
module rv32i_load_extract
  import rv32i_lsu_pkg::*;
(
  input  logic [2:0]  ld_op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);

  logic [31:0] lane;

  always_comb begin
    lane     = rdata_i >> {addr_lo_i, 3'b000};
    result_o = 32'h0;
    case (ld_op_i)
      LD_LB:   result_o = {{24{lane[7]}}, lane[7:0]};
      LD_LH:   result_o = {{16{lane[15]}}, lane[15:0]};
      LD_LW:   result_o = rdata_i;
      LD_LBU:  result_o = {24'h0, lane[7:0]};
      LD_LHU:  result_o = {16'h0, lane[15:0]};
      default: result_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// Multi-cycle load/store unit: accepts one access in IDLE, drives a held memory request,
// waits for read data with a timeout and returns a one-cycle registered response.
module rv32i_lsu
  import rv32i_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  rv32i_lsu_if.slave   bus
);

  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  lsu_req_t    cap_q, cap_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        accept;
  logic        illegal;
  logic        bad;
  logic [1:0]  size;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_result;

  rv32i_load_extract u_extract (
    .ld_op_i   (cap_q.ld_op),
    .addr_lo_i (cap_q.addr_lo),
    .rdata_i   (bus.mem_rdata),
    .result_o  (ld_result)
  );

  // Request classification and store lane formatting, from the live request fields.
  always_comb begin
    accept  = bus.req_valid && req_ready_q;
    size    = bus.req_we ? bus.req_st_fmt : bus.req_ld_op[1:0];
    illegal = bus.req_we ? (bus.req_st_fmt == 2'b11) : lsu_ld_illegal(bus.req_ld_op);
    bad     = illegal || lsu_misaligned(bus.req_addr[1:0], size);
    case (bus.req_st_fmt)
      fmt_sb: begin
        st_be    = 4'b0001 << bus.req_addr[1:0];
        st_wdata = {4{bus.req_wdata[7:0]}};
      end
      fmt_sh: begin
        st_be    = 4'b0011 << {bus.req_addr[1], 1'b0};
        st_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = bus.req_wdata;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_d        = cap_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bad) begin
            // Rejected accesses never reach the memory port.
            state_d    = RESP;
            resp_err_d = 1'b1;
          end else begin
            state_d       = REQ;
            cnt_d         = 8'h0;
            cap_d.we      = bus.req_we;
            cap_d.ld_op   = bus.req_ld_op;
            cap_d.addr_lo = bus.req_addr[1:0];
            mem_we_d      = bus.req_we;
            mem_addr_d    = {bus.req_addr[31:2], 2'b00};
            mem_be_d      = bus.req_we ? st_be : 4'b1111;
            mem_wdata_d   = bus.req_we ? st_wdata : 32'h0;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          state_d = cap_q.we ? RESP : WAIT_R;
          cnt_d   = 8'h0;
        end
      end
      WAIT_R: begin
        // Read data wins over a timeout expiring on the same cycle.
        if (bus.mem_rvalid) begin
          state_d      = RESP;
          resp_rdata_d = ld_result;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT) begin
            state_d    = RESP;
            resp_err_d = 1'b1;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    mem_req_d    = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'h0;
      cap_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_be_q     <= 4'h0;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_q        <= cap_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Bench for rv32i_lsu: directed scenarios plus randomized accesses checked against
// an arithmetic reference model of the access rules.
module tb_rv32i_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32i_lsu_if bus();
  rv32i_lsu #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  typedef struct {
    int          lat;
    bit          got_resp;
    bit          saw_req;
    int          req_cycles;
    bit          req_stable;
    int          wait_cycles;
    bit          busy_rdy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int nbytes(logic we, logic [2:0] ld, logic [1:0] fmt);
    return we ? (1 << fmt) : (1 << ld[1:0]);
  endfunction

  function automatic logic m_err(logic we, logic [2:0] ld, logic [1:0] fmt, logic [31:0] a);
    bit ill = we ? (fmt == 2'd3) : (ld == 3'd3 || ld == 3'd6 || ld == 3'd7);
    return ill || ((a % nbytes(we, ld, fmt)) != 0);
  endfunction

  function automatic logic [3:0] m_be(logic we, logic [1:0] fmt, logic [31:0] a);
    int n = 1 << fmt;
    if (!we) return 4'hF;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(logic [1:0] fmt, logic [31:0] wd);
    logic [31:0] r;
    int n = 1 << fmt;
    r = '0;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(logic [2:0] ld, logic [31:0] a, logic [31:0] rd);
    int n = 1 << ld[1:0];
    longint v = longint'(rd >> (8 * (a % 4))) & ((64'd1 << (8 * n)) - 1);
    if (!ld[2] && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return 32'(v);
  endfunction

  // ---------------- driver: one access, memory served with given delays ----------------
  task automatic run_access(input logic we, input logic [2:0] ld, input logic [1:0] fmt,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] mrdata, input int gnt_dly, input int rv_dly,
                            output obs_t o);
    bit gnt_done = 0;
    int wcnt = 0;
    o = '{default: 0};
    @(posedge clk); #1;
    bus.req_valid = 1; bus.req_we = we; bus.req_ld_op = ld; bus.req_st_fmt = fmt;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 200 && !o.got_resp; cyc++) begin
      if (bus.mem_gnt) gnt_done = 1;
      bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = $urandom;
      // junk on the request side must be ignored while busy
      bus.req_valid = 1; bus.req_we = 1'($urandom); bus.req_ld_op = 3'($urandom);
      bus.req_st_fmt = 2'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
      if (bus.resp_valid) begin
        o.got_resp = 1; o.lat = cyc; o.rdata = bus.resp_rdata; o.err = bus.resp_err;
        o.wait_cycles = wcnt;
        bus.req_valid = 0;
      end else begin
        if (bus.req_ready) o.busy_rdy = 1;
        if (bus.mem_req) begin
          if (o.req_cycles == 0) begin
            o.we = bus.mem_we; o.addr = bus.mem_addr; o.be = bus.mem_be;
            o.wdata = bus.mem_wdata; o.req_stable = 1;
          end else if ({o.we, o.addr, o.be, o.wdata} !=
                       {bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}) begin
            o.req_stable = 0;
          end
          o.saw_req = 1;
          o.req_cycles++;
          if (o.req_cycles == gnt_dly + 1) bus.mem_gnt = 1;
        end else if (gnt_done) begin
          wcnt++;
          if (wcnt == rv_dly + 1) begin bus.mem_rvalid = 1; bus.mem_rdata = mrdata; end
        end
        @(posedge clk); #1;
      end
    end
    bus.req_valid = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", bus.req_ready); end
    total++; if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== 34'h0) begin bad++;
      $display("FAIL reset_resp got=%0b/%0b/%h exp=0/0/0", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== 70'h0) begin bad++;
      $display("FAIL reset_mem got=%0b/%0b/%h/%h/%h exp=all zero", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata); end
  endtask

  task automatic test_store;
    obs_t o;
    run_access(1, 3'd0, 2'b10, 32'h100, 32'hDEADBEEF, 32'h0, 0, -1, o);
    total++; if (o.lat !== 1) begin bad++; $display("FAIL sw_latency got=%0d exp=1", o.lat); end
    total++; if ({o.we, o.be, o.addr, o.wdata} !== {1'b1, 4'hF, 32'h100, 32'hDEADBEEF}) begin bad++;
      $display("FAIL sw_mem got=%0b/%h/%h/%h exp=1/f/00000100/deadbeef", o.we, o.be, o.addr, o.wdata); end
    total++; if ({o.err, o.rdata} !== 33'h0) begin bad++; $display("FAIL sw_resp got=%0b/%h exp=0/0", o.err, o.rdata); end
    run_access(1, 3'd0, 2'b00, 32'h103, 32'h000000A5, 32'h0, 0, -1, o);
    total++; if ({o.be, o.wdata, o.addr} !== {4'b1000, 32'hA5A5A5A5, 32'h100}) begin bad++;
      $display("FAIL sb_mem got=%h/%h/%h exp=8/a5a5a5a5/00000100", o.be, o.wdata, o.addr); end
    run_access(1, 3'd0, 2'b01, 32'h102, 32'h00001234, 32'h0, 1, -1, o);
    total++; if ({o.be, o.wdata, o.err} !== {4'b1100, 32'h12341234, 1'b0}) begin bad++;
      $display("FAIL sh_mem got=%h/%h/%0b exp=c/12341234/0", o.be, o.wdata, o.err); end
    total++; if (o.lat !== 2 || o.req_cycles !== 2) begin bad++;
      $display("FAIL sh_gnt_delay got=lat%0d/req%0d exp=lat2/req2", o.lat, o.req_cycles); end
  endtask

  task automatic test_load_extract;
    obs_t o;
    logic [2:0]  ops [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] adr [5] = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h100};
    logic [31:0] exp [5] = '{32'hFFFFFFF1, 32'h000000F1, 32'hFFFF80F1, 32'h000080F1, 32'h80F17F01};
    for (int i = 0; i < 5; i++) begin
      run_access(0, ops[i], 2'b00, adr[i], 32'h0, 32'h80F17F01, 0, 0, o);
      total++; if (o.rdata !== exp[i] || o.err !== 1'b0 || o.lat !== 2) begin bad++;
        $display("FAIL load_%0d got=%h/err%0b/lat%0d exp=%h/err0/lat2", i, o.rdata, o.err, o.lat, exp[i]); end
    end
    total++; if ({o.we, o.be, o.addr} !== {1'b0, 4'hF, 32'h100}) begin bad++;
      $display("FAIL lw_mem got=%0b/%h/%h exp=0/f/00000100", o.we, o.be, o.addr); end
  endtask

  task automatic test_errors;
    obs_t o;
    logic        we  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  ld  [4] = '{3'b010, 3'b000, 3'b000, 3'b011};
    logic [1:0]  fmt [4] = '{2'b00, 2'b01, 2'b11, 2'b00};
    logic [31:0] adr [4] = '{32'h101, 32'h001, 32'h100, 32'h100};
    for (int i = 0; i < 4; i++) begin
      run_access(we[i], ld[i], fmt[i], adr[i], 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, o);
      total++; if ({o.err, o.rdata, o.saw_req} !== {1'b1, 32'h0, 1'b0} || o.lat !== 0) begin bad++;
        $display("FAIL err_%0d got=err%0b/%h/req%0b/lat%0d exp=err1/0/req0/lat0", i, o.err, o.rdata, o.saw_req, o.lat); end
    end
  endtask

  task automatic test_timeout;
    obs_t o;
    run_access(0, 3'b010, 2'b00, 32'h200, 32'h0, 32'h0, 3, -1, o);
    total++; if (o.req_cycles !== 4 || o.req_stable !== 1'b1) begin bad++;
      $display("FAIL to_req got=cyc%0d/stable%0b exp=cyc4/stable1", o.req_cycles, o.req_stable); end
    total++; if (o.wait_cycles !== 4 || o.lat !== 8) begin bad++;
      $display("FAIL to_wait got=wait%0d/lat%0d exp=wait4/lat8", o.wait_cycles, o.lat); end
    total++; if ({o.got_resp, o.err, o.rdata} !== {1'b1, 1'b1, 32'h0}) begin bad++;
      $display("FAIL to_resp got=%0b/%0b/%h exp=1/1/0", o.got_resp, o.err, o.rdata); end
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    @(posedge clk); #1;
    bus.req_valid = 1; bus.req_we = 0; bus.req_ld_op = 3'b010; bus.req_addr = 32'h300;
    @(posedge clk); #1;
    bus.req_valid = 0; bus.mem_gnt = 1;
    @(posedge clk); #1;
    bus.mem_gnt = 0;
    rst_n = 0;
    #2;
    total++; if (bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0) begin bad++;
      $display("FAIL rst_mid_async got=ready%0b/req%0b exp=ready1/req0", bus.req_ready, bus.mem_req); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    bus.mem_rvalid = 1; bus.mem_gnt = 1; bus.mem_rdata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.mem_rvalid = 0; bus.mem_gnt = 0;
      if (bus.resp_valid || bus.mem_req || !bus.req_ready || bus.resp_rdata != 0 || bus.resp_err ||
          bus.mem_addr != 0 || bus.mem_be != 0 || bus.mem_wdata != 0 || bus.mem_we) seen = 1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_after got=activity exp=idle zeros"); end
  endtask

  task automatic test_back_to_back;
    obs_t o;
    run_access(1, 3'd0, 2'b10, 32'h40, 32'h11223344, 32'h0, 0, -1, o);
    total++; if (o.busy_rdy !== 1'b0) begin bad++; $display("FAIL b2b_busy_ready got=1 exp=0"); end
    @(posedge clk); #1;
    total++; if ({bus.resp_valid, bus.mem_req, bus.req_ready} !== 3'b001) begin bad++;
      $display("FAIL b2b_idle got=%0b%0b%0b exp=001", bus.resp_valid, bus.mem_req, bus.req_ready); end
    run_access(0, 3'b000, 2'b00, 32'h43, 32'h0, 32'h7F000000, 0, 1, o);
    total++; if (o.rdata !== 32'h0000007F || o.lat !== 3) begin bad++;
      $display("FAIL b2b_load got=%h/lat%0d exp=0000007f/lat3", o.rdata, o.lat); end
  endtask

  task automatic test_random;
    obs_t o;
    for (int i = 0; i < 40; i++) begin
      logic        we  = 1'($urandom);
      logic [2:0]  ld  = 3'($urandom_range(0, 7));
      logic [1:0]  fmt = 2'($urandom_range(0, 3));
      logic [31:0] a   = $urandom;
      logic [31:0] wd  = $urandom;
      logic [31:0] rd  = $urandom;
      int          gd  = $urandom_range(0, 2);
      int          rv  = $urandom_range(0, 2);
      logic        e   = m_err(we, ld, fmt, a);
      logic [31:0] er  = (e || we) ? 32'h0 : m_rdata(ld, a, rd);
      int          el  = e ? 0 : (we ? gd + 1 : gd + rv + 2);
      run_access(we, ld, fmt, a, wd, rd, gd, rv, o);
      total++; if ({o.err, o.rdata} !== {e, er} || o.lat !== el || o.saw_req !== !e) begin bad++;
        $display("FAIL rnd_resp_%0d got=err%0b/%h/lat%0d/req%0b exp=err%0b/%h/lat%0d/req%0b",
                 i, o.err, o.rdata, o.lat, o.saw_req, e, er, el, !e); end
      if (!e) begin
        total++;
        if ({o.we, o.be, o.addr} !== {we, m_be(we, fmt, a), a & 32'hFFFFFFFC} || o.req_stable !== 1'b1 ||
            (we && o.wdata !== m_wdata(fmt, wd))) begin bad++;
          $display("FAIL rnd_mem_%0d got=%0b/%h/%h/%h exp=%0b/%h/%h/%h", i, o.we, o.be, o.addr, o.wdata,
                   we, m_be(we, fmt, a), a & 32'hFFFFFFFC, m_wdata(fmt, wd)); end
      end
    end
  endtask

  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_ld_op = 0; bus.req_st_fmt = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    #12;
    test_reset;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    test_reset;
    test_store;
    test_load_extract;
    test_errors;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
